// File: rtl/shift_reg_unload.sv
// Parallel-to-serial unloader: captures up to NUM_WORDS words in one handshake
// and drains them one word per beat on a valid/ready stream.
module shift_reg_unload #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_WORDS = 4,
    parameter logic [DATA_W-1:0] RST_VAL   = '0,
    parameter bit                REVERSE   = 1'b0,
    parameter int                CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i [NUM_WORDS],
    input  logic [CNT_W-1:0]  load_count_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o
);

    localparam int               IDX_W   = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_WORDS);

    logic [DATA_W-1:0] buf_q [NUM_WORDS];
    logic [DATA_W-1:0] buf_d [NUM_WORDS];
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic              load_accept;
    logic              beat_done;
    logic [CNT_W-1:0]  sat_cnt;
    logic [IDX_W-1:0]  first_idx;

    // A new load may land in the same cycle the final beat is taken, so no bubble.
    assign load_ready_o = (rem_q == '0) || (valid_q && ready_i && last_q);
    assign load_accept  = load_valid_i && load_ready_o;
    assign beat_done    = valid_q && ready_i;

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = valid_q;

    always_comb begin
        buf_d     = buf_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        sat_cnt   = (load_count_i > MAX_CNT) ? MAX_CNT : load_count_i;
        first_idx = REVERSE ? IDX_W'(sat_cnt - CNT_W'(1)) : '0;

        if (load_accept) begin
            buf_d = load_data_i;
            rem_d = sat_cnt;
            if (sat_cnt != '0) begin
                valid_d = 1'b1;
                data_d  = load_data_i[first_idx];
                last_d  = (sat_cnt == CNT_W'(1));
                idx_d   = REVERSE ? first_idx - IDX_W'(1) : first_idx + IDX_W'(1);
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = RST_VAL;
            end
        end else if (beat_done) begin
            // idx_q always points at the word to present after the current one.
            rem_d = rem_q - CNT_W'(1);
            if (rem_d != '0) begin
                valid_d = 1'b1;
                data_d  = buf_q[idx_q];
                last_d  = (rem_d == CNT_W'(1));
                idx_d   = REVERSE ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = RST_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= '0;
            end
            rem_q   <= '0;
            idx_q   <= '0;
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_unload.sv
// Directed bench for shift_reg_unload: forward instance plus a REVERSE=1 instance.
module tb_shift_reg_unload;

    localparam int          DW  = 32;
    localparam int          NW  = 4;
    localparam int          CW  = 3;
    localparam logic [31:0] RST = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] ld_data [NW];
    logic [CW-1:0] ld_count = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic          last;
    logic          busy;

    logic          r_load_valid = 1'b0;
    logic          r_load_ready;
    logic [DW-1:0] r_ld_data [NW];
    logic [CW-1:0] r_ld_count = '0;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          r_last;
    logic          r_busy;

    logic [DW-1:0] a_words [NW];
    logic [DW-1:0] b_words [NW];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_reg_unload #(.DATA_W(DW), .NUM_WORDS(NW), .RST_VAL(RST), .REVERSE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_data_i(ld_data), .load_count_i(ld_count),
        .data_o(data), .valid_o(valid), .ready_i(ready),
        .last_o(last), .busy_o(busy)
    );

    shift_reg_unload #(.DATA_W(DW), .NUM_WORDS(NW), .RST_VAL(RST), .REVERSE(1'b1)) dut_rev (
        .clk(clk), .rst_n(rst_n),
        .load_valid_i(r_load_valid), .load_ready_o(r_load_ready),
        .load_data_i(r_ld_data), .load_count_i(r_ld_count),
        .data_o(r_data), .valid_o(r_valid), .ready_i(r_ready),
        .last_o(r_last), .busy_o(r_busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({valid, last, busy, load_ready} !== 4'b0001 || data !== RST) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%b l=%b b=%b lr=%b d=%h, want v=0 l=0 b=0 lr=1 d=%h",
                     valid, last, busy, load_ready, data, RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (valid !== 1'b0 || data !== RST || load_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL idle_after_reset[%0d]: got v=%b d=%h lr=%b, want v=0 d=%h lr=1",
                         i, valid, data, load_ready, RST);
            end
        end
    endtask

    task automatic test_basic_drain();
        ready = 1'b1;
        ld_data = a_words;
        ld_count = 3'd4;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (valid !== 1'b1 || data !== a_words[i] || last !== (i == 3) ||
                busy !== 1'b1 || load_ready !== (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL basic_beat[%0d]: got v=%b d=%h l=%b b=%b lr=%b, want v=1 d=%h l=%b b=1 lr=%b",
                         i, valid, data, last, busy, load_ready, a_words[i], (i == 3), (i == 3));
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (valid !== 1'b0 || last !== 1'b0 || data !== RST || load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_idle: got v=%b l=%b d=%h lr=%b, want v=0 l=0 d=%h lr=1",
                     valid, last, data, load_ready, RST);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pattern;
        int k;
        pattern = 7'b1011001;
        k = 0;
        ready = 1'b1;
        ld_data = a_words;
        ld_count = 3'd4;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 7; c++) begin
            ready = pattern[6 - c];
            load_valid = ~ready;
            ld_data = b_words;
            #1;
            vectors++;
            if (valid !== 1'b1 || data !== a_words[k] || last !== (k == 3) ||
                load_ready !== ((k == 3) && ready)) begin
                miscompares++;
                $display("[TB] FAIL backpressure[%0d]: got v=%b d=%h l=%b lr=%b, want v=1 d=%h l=%b lr=%b",
                         c, valid, data, last, load_ready, a_words[k], (k == 3), ((k == 3) && ready));
            end
            if (ready) k++;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        ready = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || data !== RST || k != 4) begin
            miscompares++;
            $display("[TB] FAIL backpressure_end: got v=%b d=%h transfers=%0d, want v=0 d=%h transfers=4",
                     valid, data, k, RST);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_seq [6];
        logic          exp_last [6];
        exp_seq = '{a_words[0], a_words[1], a_words[2], a_words[3], b_words[0], b_words[1]};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ready = 1'b1;
        ld_data = a_words;
        ld_count = 3'd4;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            load_valid = (i == 3);
            if (i == 3) begin
                ld_data = b_words;
                ld_count = 3'd2;
            end
            #1;
            vectors++;
            if (valid !== 1'b1 || data !== exp_seq[i] || last !== exp_last[i] ||
                load_ready !== exp_last[i]) begin
                miscompares++;
                $display("[TB] FAIL back_to_back[%0d]: got v=%b d=%h l=%b lr=%b, want v=1 d=%h l=%b lr=%b",
                         i, valid, data, last, load_ready, exp_seq[i], exp_last[i], exp_last[i]);
            end
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        vectors++;
        if (valid !== 1'b0 || data !== RST) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_idle: got v=%b d=%h, want v=0 d=%h", valid, data, RST);
        end
    endtask

    task automatic test_counts();
        ready = 1'b1;
        ld_data = a_words;
        ld_count = 3'd0;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || data !== RST) begin
            miscompares++;
            $display("[TB] FAIL count0: got v=%b b=%b lr=%b d=%h, want v=0 b=0 lr=1 d=%h",
                     valid, busy, load_ready, data, RST);
        end

        ld_count = 3'd7;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (i < 4) begin
                if (valid !== 1'b1 || data !== a_words[i] || last !== (i == 3)) begin
                    miscompares++;
                    $display("[TB] FAIL count7_beat[%0d]: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             i, valid, data, last, a_words[i], (i == 3));
                end
            end else if (valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL count7_extra: got v=%b, want v=0", valid);
            end
            @(posedge clk);
            #1;
        end

        ld_count = 3'd1;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b1 || data !== a_words[0] || last !== 1'b1 || load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL count1_beat: got v=%b d=%h l=%b lr=%b, want v=1 d=%h l=1 lr=1",
                     valid, data, last, load_ready, a_words[0]);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (valid !== 1'b0 || last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL count1_idle: got v=%b l=%b, want v=0 l=0", valid, last);
        end
    endtask

    task automatic test_reset_mid_drain();
        ready = 1'b1;
        ld_data = a_words;
        ld_count = 3'd4;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (valid !== 1'b1 || data !== a_words[2]) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got v=%b d=%h, want v=1 d=%h", valid, data, a_words[2]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || data !== RST || load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b l=%b b=%b d=%h lr=%b, want v=0 l=0 b=0 d=%h lr=1",
                     valid, last, busy, data, load_ready, RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle[%0d]: got v=%b, want v=0", i, valid);
            end
        end
    endtask

    task automatic test_reverse();
        int order [3];
        order = '{2, 1, 0};
        r_ready = 1'b1;
        r_ld_data = a_words;
        r_ld_count = 3'd3;
        r_load_valid = 1'b1;
        @(posedge clk);
        #1;
        r_load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (i < 3) begin
                if (r_valid !== 1'b1 || r_data !== a_words[order[i]] || r_last !== (i == 2)) begin
                    miscompares++;
                    $display("[TB] FAIL reverse_beat[%0d]: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             i, r_valid, r_data, r_last, a_words[order[i]], (i == 2));
                end
            end else if (r_valid !== 1'b0 || r_data !== RST) begin
                miscompares++;
                $display("[TB] FAIL reverse_idle: got v=%b d=%h, want v=0 d=%h", r_valid, r_data, RST);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            a_words[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0011;
            b_words[i] = 32'hB000_0000 + 32'(i) * 32'h0010_0101;
            ld_data[i] = '0;
            r_ld_data[i] = '0;
        end
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_back_to_back();
        test_counts();
        test_reset_mid_drain();
        test_reverse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
